// File: rtl/mux_8_if.sv
// Lane/select bundle for the 8-to-1 mux.
// Master drives lanes, select and enable; slave returns y and y_q.
interface mux_8_if #(
  parameter int WIDTH = 1
);
  logic [8*WIDTH-1:0] d;
  logic [2:0]         s;
  logic               en;
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   y_q;

  modport master (
    output d,
    output s,
    output en,
    input  y,
    input  y_q
  );

  modport slave (
    input  d,
    input  s,
    input  en,
    output y,
    output y_q
  );
endinterface

// File: rtl/mux_8.sv
// 8-to-1 lane mux for the MIPS datapath.
// y is combinational; y_q is an enabled, async-cleared copy.
module mux_8 #(
  parameter int WIDTH = 1
) (
  input  logic   clk,
  input  logic   rst,
  mux_8_if.slave bus
);

  logic [WIDTH-1:0] lane [8];
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] sel_d;
  logic [WIDTH-1:0] sel_q;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign lane[i] = bus.d[i*WIDTH +: WIDTH];
  end

  // X/Z on s propagates to y in simulation
  always_comb begin
    y_d   = lane[bus.s];
    sel_d = bus.en ? y_d : sel_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign bus.y   = y_d;
  assign bus.y_q = sel_q;

endmodule

// File: tb/tb_mux_8.sv
// Directed bench for mux_8 (WIDTH=1).
// Inputs driven on one edge, outputs checked away from the active edge.
module tb_mux_8;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   vec_fail;

  mux_8_if #(.WIDTH(1)) bus ();

  mux_8 #(.WIDTH(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // {d[7:0], s[2:0], y_expected}
  logic [11:0] vec [16];

  initial begin
    vec = '{
      {8'h00, 3'd0, 1'b0}, {8'hFF, 3'd7, 1'b1},
      {8'h01, 3'd0, 1'b1}, {8'h80, 3'd7, 1'b1},
      {8'h7F, 3'd7, 1'b0}, {8'h55, 3'd1, 1'b0},
      {8'h55, 3'd2, 1'b1}, {8'hAA, 3'd3, 1'b1},
      {8'h0F, 3'd4, 1'b0}, {8'hF0, 3'd4, 1'b1},
      {8'h3C, 3'd5, 1'b1}, {8'h3C, 3'd6, 1'b0},
      {8'h12, 3'd1, 1'b1}, {8'h12, 3'd4, 1'b1},
      {8'hC3, 3'd2, 1'b0}, {8'hC3, 3'd6, 1'b1}
    };

    rst    = 1'b0;
    bus.en = 1'b1;
    bus.d  = 8'hFF;
    bus.s  = 3'd0;
    #7;
    chk("reset_yq", bus.y_q, 1'b0);
    chk("reset_y", bus.y, 1'b1);
    @(negedge clk);
    bus.en = 1'b0;
    rst    = 1'b1;

    // select sweep
    bus.d = 8'b1010_1010;
    for (int i = 0; i < 8; i++) begin
      bus.s = 3'(i);
      #1;
      chk($sformatf("sweep_s%0d", i), bus.y, (i % 2) == 1);
    end

    // one-hot walk
    for (int k = 0; k < 8; k++) begin
      bus.d = 8'h01 << k;
      for (int j = 0; j < 8; j++) begin
        bus.s = 3'(j);
        #1;
        chk($sformatf("onehot_k%0d_s%0d", k, j), bus.y, j == k);
      end
    end

    // endpoints
    bus.d = 8'b1000_0000; bus.s = 3'b111; #1;
    chk("end_msb_1", bus.y, 1'b1);
    bus.d = 8'b0111_1111; bus.s = 3'b111; #1;
    chk("end_msb_0", bus.y, 1'b0);
    bus.d = 8'h01; bus.s = 3'b000; #1;
    chk("end_lsb_1", bus.y, 1'b1);

    // vector table: drive on posedge, check on negedge
    vec_fail = n_fail;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      bus.d = vec[i][11:4];
      bus.s = vec[i][3:1];
      @(negedge clk);
      chk($sformatf("vec%0d", i), bus.y, vec[i][0]);
    end
    $display("Testes Efetuados = %0d", 16);
    $display("Erros Encontrados = %0d", n_fail - vec_fail);

    // register capture and hold
    @(negedge clk);
    bus.en = 1'b1; bus.d = 8'hF0; bus.s = 3'd4;
    #1;
    chk("reg_pre_edge", bus.y_q, 1'b0);
    @(posedge clk); #1;
    chk("reg_capture", bus.y_q, 1'b1);
    bus.en = 1'b0; bus.s = 3'd0;
    #1;
    chk("reg_hold_y", bus.y, 1'b0);
    @(posedge clk); #1;
    chk("reg_hold_yq", bus.y_q, 1'b1);
    @(negedge clk);
    bus.en = 1'b1;
    #1;
    chk("reg_wait_edge", bus.y_q, 1'b1);
    @(posedge clk); #1;
    chk("reg_capture0", bus.y_q, 1'b0);

    // async reset between edges
    @(negedge clk);
    bus.s = 3'd4;
    @(posedge clk); #1;
    chk("ar_setup", bus.y_q, 1'b1);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ar_clear", bus.y_q, 1'b0);
    chk("ar_y_track", bus.y, 1'b1);
    bus.s = 3'd0;
    #1;
    chk("ar_y_track0", bus.y, 1'b0);
    bus.s = 3'd7;
    @(posedge clk); #1;
    chk("ar_held_low", bus.y_q, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ar_release", bus.y_q, 1'b0);
    @(posedge clk); #1;
    chk("ar_first_cap", bus.y_q, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
